uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, replacing the fixed single-byte `uart0` transmit path in `riscv_soc`. The CPU-side peripheral bus pushes characters through a valid/ready port. The block serialises them on `uart_tx` with run-time-selectable baud divisor, parity and stop-bit count. Back-to-back frames are sent gap-free, and FIFO level and frame-done status are exposed for bus status registers and interrupts.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive blocks.
// Holds the TX FSM state type, parity encoding and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // acc is the XOR of all data bits; odd parity inverts it.
    function automatic logic parity_bit(logic acc, parity_t mode);
        return (mode == PARITY_ODD) ? ~acc : acc;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: character write port (valid/ready) into the TX FIFO.
// The bus side is the master, the transmitter is the slave.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr_valid;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together keeps count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a FIFO, gap-free frame streaming.
// Configuration is captured at each pop so mid-frame changes wait a frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic                        cfg_parity_en,
    input  logic                        cfg_parity_odd,
    input  logic                        cfg_stop2,
    uart_tx_fifo_if.slave               wr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        tx_done,
    output logic                        uart_tx
);
    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    uart_tx_state_t       state, state_n;
    logic [DIV_W-1:0]     timer, timer_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_acc, par_acc_n;
    logic [DIV_W-1:0]     div_q, div_n;
    logic                 pen_q, pen_n;
    parity_t              odd_q, odd_n;
    logic                 stop2_q, stop2_n;
    logic                 tx_q, tx_n;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 load;
    logic                 done;
    logic                 bit_end;
    logic [DATA_BITS-1:0] head;

    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid && !full;
    assign bit_end     = (timer == '0);
    assign uart_tx     = tx_q;
    assign tx_done     = done;
    assign busy        = (state != ST_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (wr.wr_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Frame sequencing: next state, timer, shifter and next line level.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_acc_n = par_acc;
        div_n     = div_q;
        pen_n     = pen_q;
        odd_n     = odd_q;
        stop2_n   = stop2_q;
        tx_n      = tx_q;
        load      = 1'b0;
        pop       = 1'b0;
        done      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                tx_n = LINE_IDLE;
                if (!empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_n   = ST_DATA;
                    timer_n   = div_q;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    par_acc_n = par_acc ^ shreg[0];
                    shreg_n   = shreg >> 1;
                    timer_n   = div_q;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        if (pen_q) begin
                            state_n = ST_PARITY;
                            tx_n    = parity_bit(par_acc ^ shreg[0], odd_q);
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = LINE_STOP;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_n      = shreg[1];
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_n = ST_STOP;
                    timer_n = div_q;
                    tx_n    = LINE_STOP;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && bit_cnt == '0) begin
                        bit_cnt_n = CNT_W'(1);
                        timer_n   = div_q;
                    end else begin
                        done = 1'b1;
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            tx_n    = LINE_IDLE;
                        end
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tx_n    = LINE_IDLE;
            end
        endcase

        if (load) begin
            pop       = 1'b1;
            state_n   = ST_START;
            timer_n   = cfg_div;
            bit_cnt_n = '0;
            shreg_n   = head;
            par_acc_n = 1'b0;
            div_n     = cfg_div;
            pen_n     = cfg_parity_en;
            odd_n     = parity_t'(cfg_parity_odd);
            stop2_n   = cfg_stop2;
            tx_n      = LINE_START;
        end
    end

    // Frame state registers; the line flop resets straight to idle-high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
            div_q   <= '0;
            pen_q   <= 1'b0;
            odd_q   <= PARITY_EVEN;
            stop2_q <= 1'b0;
            tx_q    <= LINE_IDLE;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par_acc <= par_acc_n;
            div_q   <= div_n;
            pen_q   <= pen_n;
            odd_q   <= odd_n;
            stop2_q <= stop2_n;
            tx_q    <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench with a frame-level reference model.
// The model expands each popped character into its expected line levels.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] cfg_div = '0;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_stop2 = 1'b0;
    logic [4:0]  fifo_count;
    logic        busy;
    logic        tx_done;
    logic        uart_tx;

    int checks = 0;
    int failures = 0;

    uart_tx_fifo_if #(.DATA_BITS(8)) wr_bus ();

    uart_tx_fifo #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (16)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cfg_div        (cfg_div),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .wr             (wr_bus),
        .fifo_count     (fifo_count),
        .busy           (busy),
        .tx_done        (tx_done),
        .uart_tx        (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_fifo[$];
    bit         m_wave[$];
    bit         m_take;
    logic [7:0] m_data;
    logic       exp_tx = 1'b1;
    logic       exp_done = 1'b0;
    logic       exp_ready = 1'b1;
    logic       exp_busy = 1'b0;
    int         exp_cnt = 0;

    function automatic void build_frame(input logic [7:0] d);
        int n;
        n = int'(cfg_div) + 1;
        for (int k = 0; k < n; k++) m_wave.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < n; k++) m_wave.push_back(d[b]);
        if (cfg_parity_en)
            for (int k = 0; k < n; k++)
                m_wave.push_back((^d) ^ cfg_parity_odd);
        for (int s = 0; s < (cfg_stop2 ? 2 : 1); s++)
            for (int k = 0; k < n; k++) m_wave.push_back(1'b1);
    endfunction

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_fifo.delete();
            m_wave.delete();
        end else begin
            m_take = wr_bus.wr_valid && (m_fifo.size() < DEPTH);
            m_data = wr_bus.wr_data;
            if (m_wave.size() != 0) void'(m_wave.pop_front());
            if (m_wave.size() == 0 && m_fifo.size() != 0)
                build_frame(m_fifo.pop_front());
            if (m_take) m_fifo.push_back(m_data);
        end
        exp_tx    = (m_wave.size() != 0) ? m_wave[0] : 1'b1;
        exp_done  = (m_wave.size() == 1);
        exp_cnt   = m_fifo.size();
        exp_ready = (m_fifo.size() < DEPTH);
        exp_busy  = (m_wave.size() != 0) || (m_fifo.size() != 0);
    end

    initial forever begin
        @(negedge clk);
        chk("tx", uart_tx, exp_tx);
        chk("done", tx_done, exp_done);
        chk("cnt", fifo_count, exp_cnt);
        chk("ready", wr_bus.wr_ready, exp_ready);
        chk("busy", busy, exp_busy);
    end

    // ---------------- helpers ----------------
    bit line_log[$];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [7:0] d);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data  = d;
        tick();
        wr_bus.wr_valid = 1'b0;
    endtask

    // Cycles from first low level to the tx_done cycle, inclusive.
    task automatic frame_len(input int limit, output int len, output int st);
        st  = -1;
        len = -1;
        line_log.delete();
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (st < 0 && uart_tx == 1'b0) st = i;
            if (st >= 0) line_log.push_back(uart_tx);
            if (tx_done) begin
                if (st >= 0) len = i - st + 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("drain", busy, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len, st, acc, lows, d1, d2;
        bit r, got;

        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_data  = '0;
        #1 resetn = 1'b0;
        #1;
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_ready", wr_bus.wr_ready, 1'b1);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        tick();

        // Basic 0x55 frame, 4 clocks per bit.
        cfg_div = 16'd3;
        put(8'h55);
        chk("cnt_e0", fifo_count, 1);
        @(posedge clk);
        #1;
        chk("fall_e1", uart_tx, 1'b0);
        chk("cnt_e1", fifo_count, 0);
        frame_len(100, len, st);
        chk("len_55", len, 40);
        wait_idle(100);

        // 0x07 even then odd parity, two stops, one clock per bit.
        tick();
        cfg_div = 16'd0;
        cfg_parity_en = 1'b1;
        cfg_stop2 = 1'b1;
        put(8'h07);
        frame_len(50, len, st);
        chk("len_07e", len, 12);
        chk("par_even", line_log[9], 1'b1);
        wait_idle(50);
        tick();
        cfg_parity_odd = 1'b1;
        put(8'h07);
        frame_len(50, len, st);
        chk("len_07o", len, 12);
        chk("par_odd", line_log[9], 1'b0);
        wait_idle(50);

        // Back-to-back frames must abut with no idle cycle.
        tick();
        cfg_div = 16'd1;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2 = 1'b0;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data = 8'hA5;
        tick();
        wr_bus.wr_data = 8'h3C;
        tick();
        wr_bus.wr_valid = 1'b0;
        frame_len(100, len, st);
        chk("len_a5", len, 20);
        chk("st_a5", st, 0);
        frame_len(100, len, st);
        chk("gap_start", st, 0);
        chk("len_3c", len, 20);
        wait_idle(100);

        // Parity enabled mid-frame applies only to the following frame.
        tick();
        cfg_div = 16'd2;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data = 8'($urandom);
        tick();
        wr_bus.wr_data = 8'($urandom);
        tick();
        wr_bus.wr_valid = 1'b0;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 12) cfg_parity_en = 1'b1;
            if (tx_done) begin
                if (d1 < 0) d1 = i;
                else begin
                    d2 = i;
                    break;
                end
            end
        end
        chk("cfg_f1", d1, 29);
        chk("cfg_f2", d2 - d1, 33);
        wait_idle(100);
        tick();
        cfg_parity_en = 1'b0;

        // Hold writes against a slow line until the FIFO fills.
        cfg_div = 16'd100;
        acc = 0;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = wr_bus.wr_ready;
            tick();
            if (r) begin
                acc++;
                wr_bus.wr_data = 8'($urandom);
            end
        end
        chk("accepted", acc, 17);
        chk("full_cnt", fifo_count, DEPTH);
        chk("full_ready", wr_bus.wr_ready, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = wr_bus.wr_ready;
            tick();
            if (r) begin
                got = 1'b1;
                break;
            end
        end
        chk("late_accept", got, 1'b1);
        wr_bus.wr_valid = 1'b0;
        wait_idle(25000);

        // Reset during data bit 3 with five characters queued.
        tick();
        cfg_div = 16'd3;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data = 8'h00;
        repeat (6) tick();
        wr_bus.wr_valid = 1'b0;
        chk("pre_cnt", fifo_count, 5);
        repeat (13) tick();
        chk("pre_tx", uart_tx, 1'b0);
        resetn = 1'b0;
        #1;
        chk("mid_tx", uart_tx, 1'b1);
        chk("mid_cnt", fifo_count, 0);
        chk("mid_busy", busy, 1'b0);
        repeat (2) tick();
        resetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) lows++;
        end
        chk("no_tx", lows, 0);

        // Random traffic with random per-frame settings.
        tick();
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                cfg_div = 16'($urandom_range(0, 3));
                cfg_parity_en = 1'($urandom_range(0, 1));
                cfg_parity_odd = 1'($urandom_range(0, 1));
                cfg_stop2 = 1'($urandom_range(0, 1));
            end
            wr_bus.wr_valid = ($urandom_range(0, 5) == 0);
            wr_bus.wr_data = 8'($urandom);
            tick();
        end
        wr_bus.wr_valid = 1'b0;
        wait_idle(5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
